// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder built around one shared full adder.
// Operands and carry-in are latched on start. One bit is added per clock, LSB
// first, and the sum is assembled in a right-shifting result register.
// done pulses for one cycle when sum/cout are valid. Both then hold until the
// next operation completes.
//
// Handshake: start is sampled only while idle (busy=0, done=0). A start seen in
// any other cycle is dropped, with no queuing. busy is high for exactly WIDTH
// cycles per operation. done is a single-cycle pulse, and sum/cout are valid
// from that cycle onwards.
//
// Optional build macro SERIAL_ADD_OVF_EN adds the ovf output, which reports
// two's-complement overflow of the last completed addition.

module full_add (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  assign state_dbg = state;

  // The single shared full adder always works on the current LSBs and the carry flop.
  full_add u_fa (
    .sum   (fa_sum),
    .carry (fa_carry),
    .a     (op_a[0]),
    .b     (op_b[0]),
    .cin   (carry)
  );

  // Controller FSM with registered outputs.
  // The final RUN cycle loads sum/cout directly so they are valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          op_a  <= {1'b0, op_a[WIDTH-1:1]};
          op_b  <= {1'b0, op_b[WIDTH-1:1]};
          res   <= {fa_sum, res[WIDTH-1:1]};
          carry <= fa_carry;
          if (cnt == LAST) begin
            // MSB cycle: the carry flop currently holds the carry entering the MSB.
            sum   <= {fa_sum, res[WIDTH-1:1]};
            cout  <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= carry ^ fa_carry;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8).
// Uses directed and random operations and a scoreboard of expected results.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   state_dbg;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  // Scoreboard entries are {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .state_dbg (state_dbg)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: unsigned sum as plain integer arithmetic.
  // Overflow is flagged when the signed sum falls outside the signed range.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                         input logic tc);
    longint u;
    longint s;
    logic   o;
    logic [W:0] r;
    u = longint'(ta) + longint'(tb_v) + longint'(tc);
    s = longint'($signed(ta)) + longint'($signed(tb_v)) + longint'(tc);
    o = (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
    r = u[W:0];
    return {o, r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [W-1:0] exp_sum,
                                    input logic exp_cout);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_sum"},  64'(sum),  64'(exp_sum));
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
  endtask

  // Compare the result outputs against the head of the scoreboard.
  task automatic check_result(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"},  64'(sum),  64'(e[W-1:0]));
      check({tag, "_cout"}, 64'(cout), 64'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
      check({tag, "_ovf"},  64'(ovf),  64'(e[W+1]));
`endif
    end
  endtask

  // Driver: issue one operation and check busy for W cycles and the single done pulse.
  // Must be called on a negedge with the DUT idle.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    exp_q.push_back(model(ta, tb_v, tc));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      check({tag, "_busy_run"}, 64'(busy), 64'(1));
      check({tag, "_done_run"}, 64'(done), 64'(0));
      @(negedge clk);
    end
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_busy_done"}, 64'(busy), 64'(0));
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_after"}, 64'(done), 64'(0));
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           nd;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1 rst = 1'b1;

    // Reset, then idle.
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("reset", '0, 1'b0);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_idle_outputs("idle", '0, 1'b0);
    end

    // Basic add, followed by a quiet period with no further done pulse.
    run_op("basic", 8'h35, 8'h4A, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_idle_outputs("basic_hold", 8'h7F, 1'b0);
    end

    // Carry ripple and signed overflow boundaries.
    run_op("ripple", 8'hFF, 8'h00, 1'b1);
    run_op("ovf", 8'h7F, 8'h01, 1'b0);

    // A start pulse mid-RUN must be ignored.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 3 * W; k++) begin
      if (k == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end else if (k == 4) begin
        start = 1'b0; a = W'($urandom); b = W'($urandom);
      end
      check("ignore_done", 64'(done), 64'(k == W + 1));
      if (done) begin
        nd++;
        check_result("ignore");
      end
      @(negedge clk);
    end
    check("ignore_done_count", 64'(nd), 64'(1));

    // Back-to-back operations with start held high: done every W+2 cycles.
    a = 8'h01; b = 8'h01; cin = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h01, 8'h01, 1'b1));
    nd = 0;
    for (int k = 1; k <= 3 * (W + 2) - 1; k++) begin
      @(negedge clk);
      check("b2b_done", 64'(done), 64'((k % (W + 2)) == W + 1));
      if (done) begin
        nd++;
        check_result("b2b");
      end
    end
    start = 1'b0;
    check("b2b_done_count", 64'(nd), 64'(3));
    repeat (2 * W) begin
      @(negedge clk);
      check("b2b_tail_done", 64'(done), 64'(0));
    end

    // Asynchronous reset mid-RUN, applied between clock edges.
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("abort", '0, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check("abort_ovf", 64'(ovf), 64'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      check_idle_outputs("abort_quiet", '0, 1'b0);
    end
    run_op("after_abort", 8'h01, 8'h02, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      run_op("rand", ra, rb, rc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
